// File: rtl/reg_scoreboard_if.sv
// Issue / write-back handshake bundle for reg_scoreboard.
// master: decode + write-back side driving requests; slave: the scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned IdxW = 4
);
    // Decode-side issue request
    logic            issue_valid;
    logic [IdxW-1:0] issue_src1;
    logic [IdxW-1:0] issue_src2;
    logic            issue_src1_used;
    logic            issue_src2_used;
    logic            issue_wb_en;
    logic [IdxW-1:0] issue_dest;
    logic            issue_ready;
    logic            stall;

    // Write-back commit, mirrors the register file write port
    logic            wb_en;
    logic [IdxW-1:0] wb_dest;

    modport master (
        output issue_valid, issue_src1, issue_src2, issue_src1_used, issue_src2_used,
        output issue_wb_en, issue_dest, wb_en, wb_dest,
        input  issue_ready, stall
    );

    modport slave (
        input  issue_valid, issue_src1, issue_src2, issue_src1_used, issue_src2_used,
        input  issue_wb_en, issue_dest, wb_en, wb_dest,
        output issue_ready, stall
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that hold decode while a source
// (or a saturated destination) still has an outstanding write.
// Optional feature: define REG_SCOREBOARD_BYPASS_EN to let a reader issue in the very
// cycle its last pending write commits (register file writes on the falling edge).
module reg_scoreboard #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned CNT_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_scoreboard_if.slave     bus,
    input  logic                flush,
    output logic [NREG-1:0]     busy_mask,
    output logic [15:0]         stall_cnt,
    output logic                underflow_err
);

    localparam int unsigned        IdxW   = 4;
    localparam logic [CNT_W-1:0]   CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] pending_q [NREG];
    logic [CNT_W-1:0] pending_d [NREG];
    logic [15:0]      stall_cnt_q, stall_cnt_d;
    logic             underflow_err_q, underflow_err_d;

    logic [CNT_W-1:0] src1_cnt, src2_cnt, dest_cnt;
    logic             src1_hazard, src2_hazard, dest_hazard;
    logic             issue_ready, stall, accept;

    // Hazard detection against the registered counters (pre-flush values)
    always_comb begin
        src1_cnt    = pending_q[bus.issue_src1];
        src2_cnt    = pending_q[bus.issue_src2];
        dest_cnt    = pending_q[bus.issue_dest];
        src1_hazard = bus.issue_src1_used && (src1_cnt != '0);
        src2_hazard = bus.issue_src2_used && (src2_cnt != '0);
        dest_hazard = bus.issue_wb_en && (dest_cnt == CntMax);
`ifdef REG_SCOREBOARD_BYPASS_EN
        // Last pending write lands on the falling edge of this cycle, so the read is safe
        if (src1_cnt == CntOne && bus.wb_en && bus.wb_dest == bus.issue_src1) begin
            src1_hazard = 1'b0;
        end
        if (src2_cnt == CntOne && bus.wb_en && bus.wb_dest == bus.issue_src2) begin
            src2_hazard = 1'b0;
        end
        // A same-cycle commit to the destination frees one counter slot
        if (bus.wb_en && bus.wb_dest == bus.issue_dest) begin
            dest_hazard = 1'b0;
        end
`endif
        issue_ready = !(src1_hazard || src2_hazard || dest_hazard);
        stall       = bus.issue_valid && !issue_ready;
        accept      = bus.issue_valid && issue_ready && bus.issue_wb_en;
    end

    // Counter next-state: flush wins, accept+commit on one register cancel out
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pending_d[r] = pending_q[r];
            if (flush) begin
                pending_d[r] = '0;
            end else if (accept && bus.issue_dest == IdxW'(r)) begin
                if (!(bus.wb_en && bus.wb_dest == IdxW'(r))) begin
                    pending_d[r] = pending_q[r] + CntOne;
                end
            end else if (bus.wb_en && bus.wb_dest == IdxW'(r)) begin
                if (pending_q[r] != '0) begin
                    pending_d[r] = pending_q[r] - CntOne;
                end
            end
        end
    end

    // Sticky underflow flag and saturating stall counter; both survive flush
    always_comb begin
        underflow_err_d = underflow_err_q;
        if (!flush && bus.wb_en && pending_q[bus.wb_dest] == '0) begin
            underflow_err_d = 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                pending_q[r] <= '0;
            end
            stall_cnt_q     <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                pending_q[r] <= pending_d[r];
            end
            stall_cnt_q     <= stall_cnt_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    // Output mapping
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_mask[r] = (pending_q[r] != '0);
        end
        bus.issue_ready = issue_ready;
        bus.stall       = stall;
        stall_cnt       = stall_cnt_q;
        underflow_err   = underflow_err_q;
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (either build of the bypass option).
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
    localparam logic Bypass = 1'b1;
`else
    localparam logic Bypass = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic [15:0] busy_mask;
    logic [15:0] stall_cnt;
    logic        underflow_err;
    int          n_total = 0;
    int          n_pass  = 0;
    logic [15:0] exp_stall;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.IdxW(4)) bus ();

    reg_scoreboard #(
        .NREG  (16),
        .CNT_W (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .stall_cnt     (stall_cnt),
        .underflow_err (underflow_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_valid     = 1'b0;
        bus.issue_src1      = '0;
        bus.issue_src2      = '0;
        bus.issue_src1_used = 1'b0;
        bus.issue_src2_used = 1'b0;
        bus.issue_wb_en     = 1'b0;
        bus.issue_dest      = '0;
        bus.wb_en           = 1'b0;
        bus.wb_dest         = '0;
        flush               = 1'b0;
    endtask

    task automatic issue_wr(input logic [3:0] d);
        idle();
        bus.issue_valid = 1'b1;
        bus.issue_wb_en = 1'b1;
        bus.issue_dest  = d;
    endtask

    task automatic reader(input logic [3:0] s);
        idle();
        bus.issue_valid     = 1'b1;
        bus.issue_src1      = s;
        bus.issue_src1_used = 1'b1;
    endtask

    initial begin
        idle();
        #2;
        // In reset: everything clear, ready regardless of inputs
        check("rst_busy", busy_mask, 16'h0000);
        check("rst_stall_cnt", stall_cnt, 16'h0000);
        check("rst_underflow", underflow_err, 1'b0);
        reader(4'd3);
        bus.issue_wb_en = 1'b1;
        bus.issue_dest  = 4'd3;
        bus.wb_en       = 1'b1;
        bus.wb_dest     = 4'd3;
        #1;
        check("rst_ready", bus.issue_ready, 1'b1);
        check("rst_stall", bus.stall, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Issue write to R3, then a reader of R3 stalls
        issue_wr(4'd3);
        #1 check("r3_issue_ready", bus.issue_ready, 1'b1);
        tick();
        check("r3_busy", busy_mask, 16'h0008);
        reader(4'd3);
        #1;
        check("r3_reader_ready", bus.issue_ready, 1'b0);
        check("r3_reader_stall", bus.stall, 1'b1);
        tick();
        check("stall_cnt_1", stall_cnt, 16'd1);
        tick();
        check("stall_cnt_2", stall_cnt, 16'd2);
        exp_stall = 16'd2;

        // Commit R3 while the reader waits
        bus.wb_en   = 1'b1;
        bus.wb_dest = 4'd3;
        #1 check("bypass_ready", bus.issue_ready, Bypass);
        if (!Bypass) exp_stall = exp_stall + 16'd1;
        tick();
        check("r3_busy_clear", busy_mask, 16'h0000);
        check("stall_cnt_commit", stall_cnt, exp_stall);
        reader(4'd3);
        #1 check("r3_after_ready", bus.issue_ready, 1'b1);
        tick();
        check("stall_cnt_hold", stall_cnt, exp_stall);

        // Saturate R5 at 3 pending writes
        for (int i = 0; i < 3; i++) begin
            issue_wr(4'd5);
            #1 check("r5_fill_ready", bus.issue_ready, 1'b1);
            tick();
        end
        check("r5_busy", busy_mask, 16'h0020);
        issue_wr(4'd5);
        #1;
        check("r5_full_ready", bus.issue_ready, 1'b0);
        check("r5_full_stall", bus.stall, 1'b1);
        tick();
        exp_stall = exp_stall + 16'd1;
        check("stall_cnt_full", stall_cnt, exp_stall);
        // One commit of R5 with the request withdrawn
        idle();
        bus.wb_en   = 1'b1;
        bus.wb_dest = 4'd5;
        tick();
        issue_wr(4'd5);
        #1 check("r5_fourth_ready", bus.issue_ready, 1'b1);
        tick();
        idle();
        bus.issue_wb_en = 1'b1;
        bus.issue_dest  = 4'd5;
        #1 check("r5_full_again", bus.issue_ready, 1'b0);
        check("r5_novalid_stall", bus.stall, 1'b0);

        // Same-cycle accept and commit on R7 leaves the count at 1
        issue_wr(4'd7);
        tick();
        issue_wr(4'd7);
        bus.wb_en   = 1'b1;
        bus.wb_dest = 4'd7;
        #1 check("r7_ready", bus.issue_ready, 1'b1);
        tick();
        check("r7_still_busy", busy_mask, 16'h00A0);
        idle();
        bus.wb_en   = 1'b1;
        bus.wb_dest = 4'd7;
        tick();
        check("r7_clear", busy_mask, 16'h0020);
        check("r7_no_underflow", underflow_err, 1'b0);

        // Commit to idle R9 raises sticky underflow
        idle();
        bus.wb_en   = 1'b1;
        bus.wb_dest = 4'd9;
        tick();
        check("r9_underflow", underflow_err, 1'b1);
        check("r9_busy", busy_mask, 16'h0020);
        idle();
        tick();
        check("underflow_sticky", underflow_err, 1'b1);

        // Flush: ready still uses pre-flush counters; counters clear, flags kept
        idle();
        flush               = 1'b1;
        bus.issue_src1      = 4'd5;
        bus.issue_src1_used = 1'b1;
        #1 check("flush_ready", bus.issue_ready, 1'b0);
        tick();
        check("flush_busy", busy_mask, 16'h0000);
        check("flush_underflow", underflow_err, 1'b1);
        check("flush_stall_cnt", stall_cnt, exp_stall);

        // Four writes in flight, then asynchronous reset mid-cycle
        issue_wr(4'd1); tick();
        issue_wr(4'd2); tick();
        issue_wr(4'd4); tick();
        issue_wr(4'd6); tick();
        check("inflight_busy", busy_mask, 16'h0056);
        reader(4'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_busy", busy_mask, 16'h0000);
        check("async_stall_cnt", stall_cnt, 16'h0000);
        check("async_underflow", underflow_err, 1'b0);
        check("async_ready", bus.issue_ready, 1'b1);
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
